// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the float<->int conversion units.
// Field widths, special encodings, latencies and the classification types.
package fp_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int FP_MANT_W = FP_FRAC_W + 1;
  localparam int INT_W     = 32;

  localparam logic signed [8:0]       EXP_BIAS = 9'sd127;
  localparam logic [FP_EXP_W-1:0]     EXP_INF  = 8'd255;
  localparam logic [INT_W-1:0]  INT_INDEFINITE = 32'h8000_0000;

  localparam int FP_TO_INT_LATENCY = 6;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp32_t;

  // CLS_ZERO must stay encoding 0 so cleared pipeline registers read as a zero result.
  typedef enum logic [1:0] {
    CLS_ZERO    = 2'd0,
    CLS_NORMAL  = 2'd1,
    CLS_MIN_INT = 2'd2,
    CLS_INVALID = 2'd3
  } fp_class_e;

  typedef struct packed {
    fp_class_e cls;
    logic      sign;
  } fp_ctrl_t;

endpackage

// File: rtl/int_align_shifter.sv
// Two-stage registered barrel shifter aligning a 24-bit mantissa into a 32-bit magnitude.
// Stage A shifts by multiples of 8, stage B by 0-7; control bits ride along unchanged.
module int_align_shifter
  import fp_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [FP_MANT_W-1:0] mant,
  input  logic                 left,
  input  logic [4:0]           amount,
  input  fp_ctrl_t             ctrl_in,
  output logic [INT_W-1:0]     mag,
  output fp_ctrl_t             ctrl_out
);

  logic [INT_W-1:0] ext;
  logic [INT_W-1:0] coarse_d;
  logic [INT_W-1:0] coarse_q;
  logic [INT_W-1:0] fine_d;
  logic             left_q;
  logic [2:0]       fine_amt_q;
  fp_ctrl_t         ctrl_q;

  assign ext = {{(INT_W - FP_MANT_W){1'b0}}, mant};

  always_comb begin
    coarse_d = left ? (ext << {amount[4:3], 3'b000}) : (ext >> {amount[4:3], 3'b000});
  end

  always_comb begin
    fine_d = left_q ? (coarse_q << fine_amt_q) : (coarse_q >> fine_amt_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      coarse_q   <= '0;
      left_q     <= 1'b0;
      fine_amt_q <= '0;
      ctrl_q     <= '0;
      mag        <= '0;
      ctrl_out   <= '0;
    end else begin
      coarse_q   <= coarse_d;
      left_q     <= left;
      fine_amt_q <= amount[2:0];
      ctrl_q     <= ctrl_in;
      mag        <= fine_d;
      ctrl_out   <= ctrl_q;
    end
  end

endmodule

// File: rtl/fp_to_int32.sv
// Six-stage FP32 -> int32 converter, truncating toward zero with integer-indefinite saturation.
// Token-triggered, fixed latency, one operand per cycle, no backpressure.
module fp_to_int32
  import fp_pkg::*;
#(
  parameter int tokenWidth = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [tokenWidth-1:0] in_0,
  input  logic [INT_W-1:0]      in_1,
  output logic [tokenWidth-1:0] out_0,
  output logic [INT_W-1:0]      out_1,
  output logic                  out_2
);

  // Stage 1: operand register
  fp32_t op_q;

  // Stage 2: classification and shift control
  logic signed [8:0]    exp_unb;
  fp_class_e            cls_d;
  logic                 left_d;
  logic [4:0]           amt_d;
  logic [FP_MANT_W-1:0] mant_q;
  logic                 left_q;
  logic [4:0]           amt_q;
  fp_ctrl_t             ctrl2_q;

  // Stage 3-4 outputs, stage 5 negate
  logic [INT_W-1:0] mag;
  fp_ctrl_t         ctrl4;
  logic [INT_W-1:0] res5_q;
  fp_ctrl_t         ctrl5_q;

  logic [tokenWidth-1:0] tok_q [FP_TO_INT_LATENCY];

  assign exp_unb = $signed({1'b0, op_q.exp}) - EXP_BIAS;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cls_d  = CLS_NORMAL;
    left_d = exp_unb > 9'sd23;
    // Low 5 bits of (e - 150) and (150 - e): 150 mod 32 = 22, so only exp[4:0] matters.
    amt_d  = left_d ? (op_q.exp[4:0] - 5'd22) : (5'd22 - op_q.exp[4:0]);
    if (op_q.exp == EXP_INF) begin
      cls_d = CLS_INVALID;
    end else if (op_q.exp == '0 || exp_unb < 9'sd0) begin
      cls_d = CLS_ZERO;
    end else if (exp_unb == 9'sd31) begin
      cls_d = (op_q.sign && op_q.frac == '0) ? CLS_MIN_INT : CLS_INVALID;
    end else if (exp_unb > 9'sd31) begin
      cls_d = CLS_INVALID;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= '0;
      mant_q  <= '0;
      left_q  <= 1'b0;
      amt_q   <= '0;
      ctrl2_q <= '0;
    end else begin
      op_q    <= in_1;
      mant_q  <= {1'b1, op_q.frac};
      left_q  <= left_d;
      amt_q   <= amt_d;
      ctrl2_q <= '{cls: cls_d, sign: op_q.sign};
    end
  end

  int_align_shifter u_shift (
    .clock    (clock),
    .reset_n  (reset_n),
    .mant     (mant_q),
    .left     (left_q),
    .amount   (amt_q),
    .ctrl_in  (ctrl2_q),
    .mag      (mag),
    .ctrl_out (ctrl4)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      res5_q  <= '0;
      ctrl5_q <= '0;
      out_1   <= '0;
      out_2   <= 1'b0;
    end else begin
      res5_q  <= ctrl4.sign ? (~mag + 32'd1) : mag;
      ctrl5_q <= ctrl4;
      unique case (ctrl5_q.cls)
        CLS_ZERO:    begin out_1 <= '0;             out_2 <= 1'b0; end
        CLS_NORMAL:  begin out_1 <= res5_q;         out_2 <= 1'b0; end
        CLS_MIN_INT: begin out_1 <= INT_INDEFINITE; out_2 <= 1'b0; end
        default:     begin out_1 <= INT_INDEFINITE; out_2 <= 1'b1; end
      endcase
    end
  end

  // NOTE: the token shift register is reset (unlike a RAM) so reset discards in-flight tokens.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FP_TO_INT_LATENCY; i++) tok_q[i] <= '0;
    end else begin
      tok_q[0] <= in_0;
      for (int i = 1; i < FP_TO_INT_LATENCY; i++) tok_q[i] <= tok_q[i-1];
    end
  end

  assign out_0 = tok_q[FP_TO_INT_LATENCY-1];

endmodule
